// File: rtl/vx_timeit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vx_timeit_ctrl_pkg
// Brief    : Shared types and constants for the timeit profiling controller.
// Revision : 1.0 - initial release
// ============================================================================
package vx_timeit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } timeit_state_e;

    localparam logic [1:0] c_csr_start = 2'd0;
    localparam logic [1:0] c_csr_end   = 2'd1;
    localparam logic [1:0] c_csr_ctrl  = 2'd2;
    localparam logic [1:0] c_csr_clear = 2'd3;

    localparam int c_ctrl_arm     = 0;
    localparam int c_ctrl_abort   = 1;
    localparam int c_ctrl_wid_lsb = 8;

    function automatic logic state_is_busy(input timeit_state_e s);
        return (s == ST_ARMED) || (s == ST_RUNNING);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_timeit_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : vx_timeit_ctrl_sat_counter
// Brief    : Accumulator with clear, load and saturating increment-by-N.
// Revision : 1.0 - initial release
// ============================================================================
module vx_timeit_ctrl_sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] inc_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;

    // One extra bit catches the carry-out so the result pins at all-ones.
    assign w_sum = {1'b0, r_count} + {1'b0, inc_val};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (inc) begin
            r_count <= w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vx_timeit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vx_timeit_ctrl
// Brief    : Sequences one cycle/instruction measurement window per arm.
// Revision : 1.0 - initial release
// ============================================================================
module vx_timeit_ctrl
    import vx_timeit_ctrl_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NUM_THREADS = 4,
    parameter int CMT_SIZE_W  = $clog2(5 * NUM_THREADS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  csr_wr_valid,
    input  logic [1:0]            csr_wr_addr,
    input  logic [31:0]           csr_wr_data,
    input  logic                  cmt_valid,
    input  logic [NW_BITS-1:0]    cmt_wid,
    input  logic [31:0]           cmt_pc,
    input  logic [CMT_SIZE_W-1:0] cmt_size,
    output logic                  timeit_enable,
    output logic [31:0]           timeit_start_addr,
    output logic [31:0]           timeit_end_addr,
    output logic [NW_BITS-1:0]    timeit_active,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           cycles,
    output logic [63:0]           instrs
);

    timeit_state_e      r_state;
    timeit_state_e      w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic [NW_BITS-1:0] r_active;
    logic [31:0]        r_start_addr;
    logic [31:0]        r_end_addr;

    logic w_ctrl_wr, w_clear_wr, w_start_wr, w_end_wr;
    logic w_arm_ok, w_abort_ok, w_cmt_hit, w_start_hit, w_end_hit;
    logic w_cnt_clr, w_cnt_load, w_cyc_inc, w_ins_inc;
    logic [63:0] w_size_ext;

    assign w_ctrl_wr  = csr_wr_valid && (csr_wr_addr == c_csr_ctrl);
    assign w_clear_wr = csr_wr_valid && (csr_wr_addr == c_csr_clear);
    assign w_start_wr = csr_wr_valid && (csr_wr_addr == c_csr_start) && !state_is_busy(r_state);
    assign w_end_wr   = csr_wr_valid && (csr_wr_addr == c_csr_end)   && !state_is_busy(r_state);

    assign w_arm_ok   = w_ctrl_wr && csr_wr_data[c_ctrl_arm] && !csr_wr_data[c_ctrl_abort]
                        && !state_is_busy(r_state);
    assign w_abort_ok = w_ctrl_wr && csr_wr_data[c_ctrl_abort] && state_is_busy(r_state);

    // Any ctrl/clear write in the same cycle takes priority and drops the commit.
    assign w_cmt_hit   = cmt_valid && (cmt_wid == r_active) && !w_ctrl_wr && !w_clear_wr;
    assign w_start_hit = w_cmt_hit && (cmt_pc == r_start_addr);
    assign w_end_hit   = w_cmt_hit && (cmt_pc == r_end_addr);

    assign w_size_ext = {{(64 - CMT_SIZE_W){1'b0}}, cmt_size};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cyc_inc   = 1'b0;
        w_ins_inc   = 1'b0;
        if (w_clear_wr) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
        end else if (w_arm_ok) begin
            w_state_nxt = ST_ARMED;
            w_cnt_clr   = 1'b1;
        end else if (w_abort_ok) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_start_hit) begin
                        w_cnt_load  = 1'b1;
                        w_state_nxt = w_end_hit ? ST_DONE : ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    w_cyc_inc = 1'b1;
                    w_ins_inc = w_cmt_hit;
                    if (w_end_hit) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_active     <= '0;
            r_start_addr <= '0;
            r_end_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= state_is_busy(w_state_nxt);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_arm_ok) begin
                r_active <= csr_wr_data[c_ctrl_wid_lsb +: NW_BITS];
            end
            if (w_start_wr) begin
                r_start_addr <= csr_wr_data;
            end
            if (w_end_wr) begin
                r_end_addr <= csr_wr_data;
            end
        end
    end

    vx_timeit_ctrl_sat_counter #(.WIDTH(64)) u_cycles (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (w_cnt_clr),
        .load     (w_cnt_load),
        .load_val (64'd1),
        .inc      (w_cyc_inc),
        .inc_val  (64'd1),
        .count    (cycles)
    );

    vx_timeit_ctrl_sat_counter #(.WIDTH(64)) u_instrs (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (w_cnt_clr),
        .load     (w_cnt_load),
        .load_val (w_size_ext),
        .inc      (w_ins_inc),
        .inc_val  (w_size_ext),
        .count    (instrs)
    );

    assign timeit_enable     = r_busy;
    assign busy              = r_busy;
    assign done              = r_done;
    assign timeit_active     = r_active;
    assign timeit_start_addr = r_start_addr;
    assign timeit_end_addr   = r_end_addr;

endmodule
`default_nettype wire

// File: doc/vx_timeit_ctrl.md
Name: VX_timeit_ctrl

Overview:
- Profiling controller: sequences one "timeit" measurement window per arm command, for a single selected warp.
- Programmed by the CSR unit. Drives the start/end PC and enable toward the commit stage.
- Watches per-cycle commit reports and counts elapsed cycles and committed instructions between a start-PC commit and an end-PC commit.
- Sits beside the CSR file; results are read back as 64-bit counters.

Parameters:
- NUM_WARPS, 4, warps per core.
- NW_BITS, $clog2(NUM_WARPS) (min 1), warp-id width.
- NUM_THREADS, 4, threads per warp.
- CMT_SIZE_W, $clog2(5*NUM_THREADS+1) = 5, commit-size width (6*NUM_THREADS when EXT_F_ENABLE).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- csr_wr_valid  in  1  CSR write strobe.
- csr_wr_addr  in  2  0=start_addr, 1=end_addr, 2=ctrl, 3=clear.
- csr_wr_data  in  32  write data.
- cmt_valid  in  1  commit report valid this cycle.
- cmt_wid  in  NW_BITS  warp id of the commit.
- cmt_pc  in  32  PC of the committed instruction.
- cmt_size  in  CMT_SIZE_W  instructions retired this cycle.
- timeit_enable  out  1  measurement armed or running.
- timeit_start_addr  out  32  programmed start PC.
- timeit_end_addr  out  32  programmed end PC.
- timeit_active  out  NW_BITS  warp under measurement.
- busy  out  1  state is ARMED or RUNNING.
- done  out  1  state is DONE.
- cycles  out  64  measured cycle count.
- instrs  out  64  measured instruction count.

Behaviour:
- Reset (async assert, sync-release use): state=IDLE; every output and register = 0.
- All outputs come straight from flops. Every event updates outputs on the next clock edge.
- ctrl write fields:
  - bit0 = arm.
  - bit1 = abort.
  - bits[8 +: NW_BITS] = warp select.
- FSM states: IDLE, ARMED, RUNNING, DONE.
- IDLE/DONE + ctrl arm:
  - → ARMED.
  - cycles=0, instrs=0.
  - timeit_active latched from the warp-select field.
- ARMED + match, where match = cmt_valid && cmt_wid==timeit_active && cmt_pc==start_addr:
  - → RUNNING.
  - cycles=1, instrs=cmt_size.
  - If the same commit also has cmt_pc==end_addr: → DONE directly, with cycles=1, instrs=cmt_size.
- RUNNING, every cycle:
  - cycles += 1.
  - If cmt_valid && cmt_wid==timeit_active: instrs += cmt_size (zero-extended).
  - If that commit also has cmt_pc==end_addr: → DONE; the end commit and its cycle are counted.
- Commits from other warps are ignored in every state.
- Start-PC matches while RUNNING do not restart the window.
- ctrl abort in ARMED/RUNNING: → IDLE; counters hold their current values.
  - Abort and arm set in the same write: abort wins.
- Arm while ARMED/RUNNING: ignored.
- Writes to start_addr/end_addr:
  - Accepted only in IDLE or DONE.
  - Ignored while busy; the registers hold.
- clear write (any data), any state: → IDLE, cycles=0, instrs=0. timeit_active is held.
- A CSR ctrl/clear write and a commit match in the same cycle: the CSR action wins and the commit is dropped.
- Counters saturate at 2^64-1 and never wrap.
- timeit_enable = busy. done is a level and holds until the next arm or clear.
- Reset mid-measurement: immediate return to IDLE with all counters at 0.

Decomposition:
- Shared package VX_timeit_pkg holds:
  - state enum (IDLE=0, ARMED=1, RUNNING=2, DONE=3);
  - CSR sub-address constants;
  - ctrl bit positions (ARM=0, ABORT=1, WID_LSB=8).
- Sub-module VX_sat_counter: 64-bit accumulator with load, clear, increment-by-N and saturation. Instantiated twice (cycles, instrs).
- The FSM and the match logic stay in the top module.

Test Plan:
- Basic window:
  - Stimulus: start=0x80000100, end=0x80000140; arm warp 2; warp-2 commits at the start PC (size 4), then two commits of size 4 over 5 cycles, then the end PC (size 4) 3 cycles later.
  - Required: done=1, cycles=9, instrs=16, busy=0.
- Warp filter: same setup, but warp 1 commits the start and end PCs → state stays ARMED, cycles=0, instrs=0.
- Same-commit start==end: start=end=0x200; warp-0 commit size 3 → DONE next edge, cycles=1, instrs=3.
- Abort and precedence:
  - Abort while RUNNING at cycles=6 → IDLE, cycles holds 6.
  - An arm+abort write → IDLE.
  - A start_addr write while busy leaves the register unchanged.
- Reset mid-run: assert reset_n=0 asynchronously between edges while RUNNING → all outputs 0 immediately; after release the block stays IDLE.
- Saturation: force cycles to 2^64-2 in RUNNING; after 3 cycles → 2^64-1, no wrap.
